tilt_cursor_filter: RTL and testbench

//  Downstream of the accelerometer SPI controller. Takes signed X/Y samples with a valid strobe.

---
 rtl/tilt_cursor_filter_if.sv | 24 ++
 rtl/tilt_cursor_filter.sv | 160 ++++++++++++++++
 tb/tb_tilt_cursor_filter.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/tilt_cursor_filter_if.sv
// Sample-in / filtered-cursor-out bundle between the accelerometer front end,
// the tilt filter and the VGA drawing logic.
interface tilt_cursor_filter_if;
   logic               iVALID;
   logic signed [15:0] iDATA_X;
   logic signed [15:0] iDATA_Y;
   logic               oBUSY;
   logic               oVALID;
   logic               oPRIMED;
   logic signed [15:0] oAVG_X;
   logic signed [15:0] oAVG_Y;
   logic [9:0]         oPOS_X;
   logic [9:0]         oPOS_Y;

   modport master (
      output iVALID, iDATA_X, iDATA_Y,
      input  oBUSY, oVALID, oPRIMED, oAVG_X, oAVG_Y, oPOS_X, oPOS_Y
   );

   modport slave (
      input  iVALID, iDATA_X, iDATA_Y,
      output oBUSY, oVALID, oPRIMED, oAVG_X, oAVG_Y, oPOS_X, oPOS_Y
   );
endinterface

// File: rtl/tilt_cursor_filter.sv
// Moving-average tilt filter with dead zone, integrating each axis into a
// saturating cursor position. One sample every three cycles (IDLE -> SUM -> POS).
module tilt_cursor_filter #(
   parameter int LOG2_DEPTH = 3,
   parameter int DEAD_ZONE  = 32,
   parameter int STEP_SHIFT = 5,
   parameter int X_MAX      = 639,
   parameter int Y_MAX      = 479
) (
   input  logic                 iCLK,
   input  logic                 iRST,
   tilt_cursor_filter_if.slave  bus
);
   localparam int                    DEPTH     = 1 << LOG2_DEPTH;
   localparam int                    SW        = 16 + LOG2_DEPTH;
   localparam logic [LOG2_DEPTH:0]   FILL_FULL = (LOG2_DEPTH + 1)'(DEPTH);
   localparam logic [LOG2_DEPTH:0]   FILL_ONE  = (LOG2_DEPTH + 1)'(1);
   localparam logic [LOG2_DEPTH-1:0] WPTR_ONE  = LOG2_DEPTH'(1);
   localparam logic signed [16:0]    DZ_S      = 17'(DEAD_ZONE);

   typedef enum logic [1:0] {S_IDLE, S_SUM, S_POS} state_t;

   state_t                 state_q, state_d;
   logic [LOG2_DEPTH-1:0]  wptr_q, wptr_d;
   logic [LOG2_DEPTH:0]    fill_q, fill_d;
   logic                   primed_q, primed_d;
   logic                   fill_full;

   assign fill_full = (fill_q == FILL_FULL);

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         state_q  <= S_IDLE;
         wptr_q   <= '0;
         fill_q   <= '0;
         primed_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         wptr_q   <= wptr_d;
         fill_q   <= fill_d;
         primed_q <= primed_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      wptr_d   = wptr_q;
      fill_d   = fill_q;
      primed_d = primed_q;
      case (state_q)
         S_IDLE: if (bus.iVALID) state_d = S_SUM;
         S_SUM: begin
            wptr_d  = wptr_q + WPTR_ONE;
            if (!fill_full) fill_d = fill_q + FILL_ONE;
            state_d = S_POS;
         end
         S_POS: begin
            if (fill_full) primed_d = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign bus.oBUSY   = (state_q != S_IDLE);
   assign bus.oVALID  = (state_q == S_POS);
   assign bus.oPRIMED = primed_q;

   for (genvar gi = 0; gi < 2; gi++) begin : g_axis
      localparam int          AXIS_MAX = (gi == 0) ? X_MAX : Y_MAX;
      localparam logic [17:0] MAX_W    = 18'(AXIS_MAX);
      localparam logic [9:0]  POS_RST  = 10'(AXIS_MAX / 2);

      logic signed [15:0]   din;
      logic signed [15:0]   buf_mem [DEPTH];
      logic signed [15:0]   old_q, old_val;
      logic signed [15:0]   sample_q, sample_d;
      logic signed [15:0]   avg_q, avg_d, avg_now;
      logic signed [SW-1:0] sum_q, sum_d;
      logic [9:0]           pos_q, pos_d, pos_next;
      logic signed [16:0]   avg_ext;
      logic [16:0]          excess, step;
      logic [17:0]          pos_w, step_w, pos_up;
      logic                 move_up, move_dn;

      if (gi == 0) begin : g_x
         assign din         = bus.iDATA_X;
         assign bus.oAVG_X  = avg_q;
         assign bus.oPOS_X  = pos_q;
      end else begin : g_y
         assign din         = bus.iDATA_Y;
         assign bus.oAVG_Y  = avg_q;
         assign bus.oPOS_Y  = pos_q;
      end

      // Sample history has no reset: slots not yet written since reset are
      // masked to zero through the fill count instead.
      always_ff @(posedge iCLK) begin
         if (state_q == S_SUM) buf_mem[wptr_q] <= sample_q;
         old_q <= buf_mem[wptr_q];
      end

      always_ff @(posedge iCLK) begin
         if (iRST) begin
            sample_q <= '0;
            sum_q    <= '0;
            avg_q    <= '0;
            pos_q    <= POS_RST;
         end else begin
            sample_q <= sample_d;
            sum_q    <= sum_d;
            avg_q    <= avg_d;
            pos_q    <= pos_d;
         end
      end

      always_comb begin
         old_val = fill_full ? old_q : '0;
         // Upper bits of the sum are exactly the floor of sum / DEPTH.
         avg_now = $signed(sum_q[SW-1:LOG2_DEPTH]);
         avg_ext = {avg_now[15], avg_now};
         move_up = 1'b0;
         move_dn = 1'b0;
         excess  = '0;
         if (avg_ext > DZ_S) begin
            move_up = 1'b1;
            excess  = avg_ext - DZ_S;
         end else if (avg_ext < -DZ_S) begin
            move_dn = 1'b1;
            excess  = -avg_ext - DZ_S;
         end
         step = excess >> STEP_SHIFT;
         if (step == '0) step = 17'd1;
         pos_w  = {8'd0, pos_q};
         step_w = {1'b0, step};
         pos_up = pos_w + step_w;

         pos_next = pos_q;
         if (move_up)
            pos_next = (pos_up > MAX_W) ? MAX_W[9:0] : pos_up[9:0];
         else if (move_dn)
            pos_next = (step_w >= pos_w) ? 10'd0 : (pos_q - step[9:0]);

         sample_d = sample_q;
         sum_d    = sum_q;
         avg_d    = avg_q;
         pos_d    = pos_q;
         case (state_q)
            S_IDLE: if (bus.iVALID) sample_d = din;
            S_SUM:  sum_d = sum_q - {{LOG2_DEPTH{old_val[15]}}, old_val}
                                  + {{LOG2_DEPTH{sample_q[15]}}, sample_q};
            S_POS: begin
               avg_d = avg_now;
               if (fill_full) pos_d = pos_next;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_tilt_cursor_filter.sv
// Directed and randomized checks of tilt_cursor_filter against a window-based
// reference model of the moving average, dead zone and cursor clamp.
module tb_tilt_cursor_filter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   fails = 0;

   // Reference model: last 8 samples per axis, fill count, cursor
   int   hist [2][8];
   int   mwp, mcnt;
   int   mpos [2];
   int   mavg [2];

   tilt_cursor_filter_if bus ();

   tilt_cursor_filter dut (
      .iCLK (clk),
      .iRST (rst),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic signed [31:0] obs,
                      input logic signed [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int floor_div8(input int s);
      int q;
      q = s / 8;
      if ((s % 8 != 0) && (s < 0)) q = q - 1;
      return q;
   endfunction

   function automatic int move(input int p, input int avg, input int lim);
      int d;
      if (avg > 32) begin
         d = (avg - 32) / 32;
         if (d < 1) d = 1;
         return (p + d > lim) ? lim : p + d;
      end else if (avg < -32) begin
         d = (-avg - 32) / 32;
         if (d < 1) d = 1;
         return (p - d < 0) ? 0 : p - d;
      end
      return p;
   endfunction

   task automatic model_reset();
      for (int a = 0; a < 2; a++) begin
         for (int k = 0; k < 8; k++) hist[a][k] = 0;
         mavg[a] = 0;
      end
      mpos[0] = 319;
      mpos[1] = 239;
      mwp  = 0;
      mcnt = 0;
   endtask

   task automatic model_push(input int x, input int y);
      int s;
      hist[0][mwp] = x;
      hist[1][mwp] = y;
      mwp = (mwp + 1) % 8;
      if (mcnt < 8) mcnt++;
      for (int a = 0; a < 2; a++) begin
         s = 0;
         for (int k = 0; k < 8; k++) s += hist[a][k];
         mavg[a] = floor_div8(s);
         if (mcnt == 8) mpos[a] = move(mpos[a], mavg[a], (a == 0) ? 639 : 479);
      end
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_busy"},   bus.oBUSY, 0);
      chk({tag, "_valid"},  bus.oVALID, 0);
      chk({tag, "_primed"}, bus.oPRIMED, 0);
      chk({tag, "_avg_x"},  bus.oAVG_X, 0);
      chk({tag, "_avg_y"},  bus.oAVG_Y, 0);
      chk({tag, "_pos_x"},  bus.oPOS_X, 319);
      chk({tag, "_pos_y"},  bus.oPOS_Y, 239);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      bus.iVALID = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      check_reset_values("reset");
      model_reset();
   endtask

   // One sample through the pipe; optionally pokes iVALID with junk while busy.
   task automatic send(input int x, input int y, input bit noise);
      int cyc = 0;
      while (bus.oBUSY && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      chk("idle_before_send", bus.oBUSY, 0);
      bus.iVALID  = 1'b1;
      bus.iDATA_X = 16'(x);
      bus.iDATA_Y = 16'(y);
      @(negedge clk);
      chk("busy_in_sum", bus.oBUSY, 1);
      chk("no_valid_in_sum", bus.oVALID, 0);
      bus.iVALID  = noise;
      bus.iDATA_X = 16'($urandom);
      bus.iDATA_Y = 16'($urandom);
      @(negedge clk);
      chk("valid_pulse", bus.oVALID, 1);
      bus.iDATA_X = 16'($urandom);
      @(negedge clk);
      bus.iVALID = 1'b0;
      model_push(x, y);
      chk("valid_one_cycle", bus.oVALID, 0);
      chk("idle_after", bus.oBUSY, 0);
      chk("avg_x", bus.oAVG_X, mavg[0]);
      chk("avg_y", bus.oAVG_Y, mavg[1]);
      chk("pos_x", bus.oPOS_X, mpos[0]);
      chk("pos_y", bus.oPOS_Y, mpos[1]);
      chk("primed", bus.oPRIMED, (mcnt == 8) ? 1 : 0);
      $display("[TB] sample x=%0d y=%0d -> avg=(%0d,%0d) pos=(%0d,%0d) primed=%0d",
               x, y, bus.oAVG_X, bus.oAVG_Y, bus.oPOS_X, bus.oPOS_Y, bus.oPRIMED);
   endtask

   initial begin
      logic [11:0]        vmask;
      logic signed [15:0] r16;
      int                 x, y, nv;

      bus.iVALID  = 1'b0;
      bus.iDATA_X = '0;
      bus.iDATA_Y = '0;

      // Reset and fill
      do_reset();
      for (int k = 1; k <= 8; k++) begin
         send(256, 0, 1'b0);
         chk("fill_avg_x", bus.oAVG_X, 32 * k);
         chk("fill_primed", bus.oPRIMED, (k == 8) ? 1 : 0);
         chk("fill_pos_x", bus.oPOS_X, (k == 8) ? 326 : 319);
         chk("fill_pos_y", bus.oPOS_Y, 239);
      end

      // Saturation at both ends
      do_reset();
      for (int k = 0; k < 8; k++) send(0, 0, 1'b0);
      for (int k = 0; k < 20; k++) send(1000, 0, 1'b1);
      chk("sat_hi_x", bus.oPOS_X, 639);
      for (int k = 0; k < 40; k++) send(-1000, 0, 1'b1);
      chk("sat_lo_x", bus.oPOS_X, 0);

      // Dead zone boundary
      do_reset();
      for (int k = 0; k < 8; k++) send(20, 0, 1'b0);
      for (int k = 0; k < 16; k++) begin
         send((k % 2 == 0) ? 32 : -32, 0, 1'b0);
         chk("dz_hold_x", bus.oPOS_X, 319);
      end
      for (int k = 0; k < 8; k++) send(33, 0, 1'b0);
      chk("dz_edge_avg", bus.oAVG_X, 33);
      chk("dz_edge_pos", bus.oPOS_X, 320);

      // iVALID held 9 cycles: accepts on edges 0, 3, 6
      do_reset();
      @(negedge clk);
      bus.iVALID  = 1'b1;
      bus.iDATA_X = 16'sd100;
      bus.iDATA_Y = -16'sd50;
      vmask = '0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         vmask[i] = bus.oVALID;
         if (i == 8) bus.iVALID = 1'b0;
      end
      chk("hs_valid_mask", vmask, 12'b0000_1001_0010);
      for (int k = 0; k < 3; k++) model_push(100, -50);
      chk("hs_avg_x", bus.oAVG_X, mavg[0]);
      chk("hs_avg_y", bus.oAVG_Y, mavg[1]);
      $display("[TB] handshake valid mask=%b avg=(%0d,%0d)", vmask, bus.oAVG_X, bus.oAVG_Y);

      // Reset in the SUM cycle
      send(500, 500, 1'b0);
      @(negedge clk);
      bus.iVALID  = 1'b1;
      bus.iDATA_X = 16'sd4000;
      bus.iDATA_Y = 16'sd4000;
      @(negedge clk);
      bus.iVALID = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_reset_values("midrst");
      nv = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (bus.oVALID) nv++;
      end
      chk("midrst_no_valid", nv, 0);
      model_reset();
      send(800, -80, 1'b0);
      chk("midrst_first_avg_x", bus.oAVG_X, 100);
      chk("midrst_first_avg_y", bus.oAVG_Y, -10);
      $display("[TB] reset mid-op: first sample avg=(%0d,%0d)", bus.oAVG_X, bus.oAVG_Y);

      // Randomized samples including the extremes
      do_reset();
      for (int k = 0; k < 80; k++) begin
         r16 = 16'($urandom);
         x = r16;
         r16 = 16'($urandom);
         y = r16;
         case ($urandom_range(0, 7))
            0: x = -32768;
            1: y = 32767;
            2: begin x = $urandom_range(0, 80) - 40; y = -32768; end
            default: ;
         endcase
         repeat ($urandom_range(0, 3)) @(negedge clk);
         send(x, y, 1'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
